instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the program counter, drives the word

---
 rtl/instruction_fetch_unit_pkg.sv | 18 +
 rtl/instruction_fetch_unit_fetch_queue.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 74 +++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, PC step, reset PC
// and the layout of a prefetch queue entry.
package instruction_fetch_unit_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam int          ADDR_WIDTH       = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          ENTRY_WIDTH      = ADDR_WIDTH + INSTR_WIDTH;

    // One prefetched word together with the PC it was fetched from
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// Flush empties the queue and overrides any push in the same cycle.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [ENTRY_WIDTH-1:0] push_data,
    input  logic                   pop,
    output logic [ENTRY_WIDTH-1:0] head_data,
    output logic                   head_valid,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_valid = ~empty;
    assign head_data  = storage[rd_ptr];

    // Pointer/occupancy bookkeeping; the pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory combinationally,
// buffers fetched words in a prefetch queue and presents them to decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    input  logic                   fetch_enable,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INSTR_WIDTH-1:0] if_instruction,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic [31:0]            fetch_count
);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic                   pop;
    logic                   push;
    logic                   queue_full;
    logic                   queue_empty;
    logic                   queue_head_valid;
    logic [ENTRY_WIDTH-1:0] queue_head_data;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;

    assign imem_address = fetch_pc;
    assign pop          = queue_head_valid & if_ready;
    // A slot freed by this cycle's pop can be refilled in the same cycle; redirect suppresses fetch
    assign push         = fetch_enable & ~redirect_valid & (~queue_full | pop);

    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = imem_instruction;
    assign head_entry       = fetch_entry_t'(queue_head_data);

    assign if_valid       = queue_head_valid;
    assign if_pc          = queue_empty ? '0 : head_entry.pc;
    assign if_instruction = queue_empty ? NOP_INSTR : head_entry.instr;

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop & ~redirect_valid),
        .head_data  (queue_head_data),
        .head_valid (queue_head_valid),
        .full       (queue_full),
        .empty      (queue_empty)
    );

    // PC and fetch counter: redirect wins, otherwise advance one word per push
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (push) begin
            fetch_pc    <= fetch_pc + PC_STEP;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] model_q [$];
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    instruction_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .fetch_enable     (fetch_enable),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .fetch_count      (fetch_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Instruction memory answers combinationally, word-indexed, aliasing above 255 words
    assign imem_instruction = mem[imem_address[9:2]];

    // Drive one cycle of inputs, advance the reference model by the same rules, then clock
    task automatic applyStimulus(input logic r, input logic fe, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        logic        do_pop;
        logic        do_push;
        logic [31:0] word;
        rst            = r;
        fetch_enable   = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        if (r) begin
            model_q.delete();
            model_pc  = 32'h0000_0000;
            model_cnt = 32'd0;
        end else begin
            do_pop = (model_q.size() > 0) && rdy;
            if (rv) begin
                model_q.delete();
                model_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                do_push = fe && ((model_q.size() < DEPTH) || do_pop);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    word = mem[model_pc[9:2]];
                    model_q.push_back({model_pc, word});
                    model_pc  = model_pc + 32'd4;
                    model_cnt = model_cnt + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Compare every observable output against the model
    task automatic checkOutput(input string tag);
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        exp_valid = (model_q.size() > 0);
        exp_pc    = exp_valid ? model_q[0][63:32] : 32'h0;
        exp_instr = exp_valid ? model_q[0][31:0]  : 32'h0;

        compared++;
        assert (if_valid === exp_valid) else begin
            mismatched++;
            $error("[TB] FAIL %s if_valid observed=%0b expected=%0b", tag, if_valid, exp_valid);
        end
        compared++;
        assert (if_pc === exp_pc) else begin
            mismatched++;
            $error("[TB] FAIL %s if_pc observed=%h expected=%h", tag, if_pc, exp_pc);
        end
        compared++;
        assert (if_instruction === exp_instr) else begin
            mismatched++;
            $error("[TB] FAIL %s if_instruction observed=%h expected=%h", tag, if_instruction, exp_instr);
        end
        compared++;
        assert (imem_address === model_pc) else begin
            mismatched++;
            $error("[TB] FAIL %s imem_address observed=%h expected=%h", tag, imem_address, model_pc);
        end
        compared++;
        assert (fetch_count === model_cnt) else begin
            mismatched++;
            $error("[TB] FAIL %s fetch_count observed=%0d expected=%0d", tag, fetch_count, model_cnt);
        end
    endtask

    // Directed scenarios then randomized traffic
    initial begin
        logic        r_rst;
        logic        r_fe;
        logic        r_rv;
        logic        r_rdy;
        logic [31:0] r_pc;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = 32'h2008_0001;
        mem[1]  = 32'h2009_0002;
        mem[2]  = 32'h0109_5020;
        mem[3]  = 32'h0800_0000;
        mem[64] = 32'hAC0A_0000;

        rst = 1'b1; fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;

        $display("[TB] reset and streaming");
        applyStimulus(1, 1, 0, 0, 1); checkOutput("reset1");
        applyStimulus(1, 1, 0, 0, 1); checkOutput("reset2");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 1); checkOutput("stream");
        end

        $display("[TB] backpressure");
        applyStimulus(1, 1, 0, 0, 0); checkOutput("bp_reset");
        applyStimulus(1, 1, 0, 0, 0); checkOutput("bp_reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0); checkOutput("bp_hold");
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 1); checkOutput("bp_release");
        end

        $display("[TB] redirect at head pc 8");
        applyStimulus(1, 1, 0, 0, 1); checkOutput("rd_reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1); checkOutput("rd_pre");
        end
        applyStimulus(0, 1, 1, 32'h103, 1); checkOutput("rd_flush");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1); checkOutput("rd_target");
        end

        $display("[TB] redirect with pop on a full queue");
        applyStimulus(0, 1, 0, 0, 0); checkOutput("rpf_fill");
        applyStimulus(0, 1, 0, 0, 0); checkOutput("rpf_fill");
        applyStimulus(0, 1, 1, 32'h8, 1); checkOutput("rpf_redirect");
        applyStimulus(0, 1, 0, 0, 1); checkOutput("rpf_after");

        $display("[TB] drain with fetch disabled");
        applyStimulus(0, 1, 0, 0, 0); checkOutput("drain_fill");
        applyStimulus(0, 1, 0, 0, 0); checkOutput("drain_fill");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1); checkOutput("drain");
        end
        applyStimulus(0, 0, 1, 32'h40, 1); checkOutput("drain_redirect");

        $display("[TB] address wrap");
        applyStimulus(0, 1, 1, 32'hFFFF_FFFE, 1); checkOutput("wrap_redirect");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 1); checkOutput("wrap");
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_fe  = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_03FF);
            applyStimulus(r_rst, r_fe, r_rv, r_pc, r_rdy); checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
